// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types: transfer/size encodings, response codes, slave FSM states
// and the little-endian byte-lane helper.
package ahb_pkg;

  typedef logic [31:0] AHB_ADDR_T;
  typedef logic [31:0] AHB_DATA_T;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

  function automatic logic [3:0] byte_en(input logic [2:0] hsize, input logic [1:0] lo);
    case (hsize_e'(hsize))
      HSIZE_BYTE: byte_en = 4'b0001 << lo;
      HSIZE_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: byte_en = 4'b1111;
      default:    byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_core.sv
// DEPTH x 32 storage: synchronous byte-enabled write, combinational read port.
// Contents are never reset.
module ahb_sram_core
  import ahb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             hclk,
  input  logic             wr_en,
  input  logic [3:0]       wr_be,
  input  logic [IDX_W-1:0] wr_idx,
  input  AHB_DATA_T        wr_dat,
  input  logic [IDX_W-1:0] rd_idx,
  output AHB_DATA_T        rd_dat
);

  AHB_DATA_T mem [DEPTH];

  always_ff @(posedge hclk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: read latency 1+READ_WAIT, write 1+WRITE_WAIT, two-cycle ERROR.
// Stalls the bus with hreadyout=0 during wait states and the first ERROR cycle.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 0
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RD_WAIT4 = READ_WAIT[3:0];
  localparam logic [3:0] WR_WAIT4 = WRITE_WAIT[3:0];

  if (READ_WAIT < 0 || READ_WAIT > 15 || WRITE_WAIT < 0 || WRITE_WAIT > 15) begin : g_bad_wait
    $fatal(1, "ahb_sram_slave: READ_WAIT/WRITE_WAIT must be within 0..15");
  end
  if (DATA_W != 32) begin : g_bad_width
    $fatal(1, "ahb_sram_slave: only DATA_W=32 is supported");
  end

  sram_state_e      state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lo_q;
  logic [2:0]       size_q;
  logic             write_q;

  logic             accept, acc_err;
  logic [3:0]       acc_wait;
  logic             wr_commit, rd_load;
  logic [3:0]       wr_be;
  logic [IDX_W-1:0] rd_idx;
  AHB_DATA_T        rd_dat, rd_byp;

  // hreadyout is folded in so a misbehaving interconnect cannot overlap a stalled data phase
  assign accept  = hsel && hready && hreadyout && (htrans_e'(htrans) inside {NONSEQ, SEQ});
  assign acc_err = ((haddr >> 2) >= ADDR_W'(DEPTH)) || (hsize > 3'd2)
                || ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign acc_wait = hwrite ? WR_WAIT4 : RD_WAIT4;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DONE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (accept) begin
          if (acc_err) begin
            state_d = ST_ERR1;
          end else if (acc_wait != 4'd0) begin
            state_d = ST_WAIT;
            cnt_d   = acc_wait;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
    endcase
  end

  always_comb begin
    hreadyout = !(state_q inside {ST_WAIT, ST_ERR1});
    hresp     = (state_q inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      idx_q   <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      idx_q   <= haddr[IDX_W+1:2];
      lo_q    <= haddr[1:0];
      size_q  <= hsize;
      write_q <= hwrite;
    end
  end

  assign wr_commit = (state_q == ST_DONE) && write_q;
  assign wr_be     = byte_en(size_q, lo_q);
  assign rd_idx    = (state_q == ST_WAIT) ? idx_q : haddr[IDX_W+1:2];
  assign rd_load   = (accept && !acc_err && !hwrite && (RD_WAIT4 == 4'd0))
                  || ((state_q == ST_WAIT) && (cnt_q == 4'd1) && !write_q);

  ahb_sram_core #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_core (
    .hclk   (hclk),
    .wr_en  (wr_commit),
    .wr_be  (wr_be),
    .wr_idx (idx_q),
    .wr_dat (hwdata),
    .rd_idx (rd_idx),
    .rd_dat (rd_dat)
  );

  // A zero-wait read accepted while a write commits must see the new bytes.
  always_comb begin
    rd_byp = rd_dat;
    for (int i = 0; i < 4; i++) begin
      if (wr_commit && wr_be[i] && (idx_q == rd_idx)) rd_byp[8*i +: 8] = hwdata[8*i +: 8];
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hrdata <= '0;
    end else if (rd_load) begin
      hrdata <= rd_byp;
    end else if (accept && acc_err) begin
      hrdata <= '0;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave (READ_WAIT=2, WRITE_WAIT=0, DEPTH=256).
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  assign hready = hreadyout;

  ahb_sram_slave #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(256), .READ_WAIT(2), .WRITE_WAIT(0)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    bit          resp;
    int          waits;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  // Issue one transfer; returns once the address phase has been accepted.
  task automatic xfer(input string nm, input bit w, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] wd, input logic [31:0] exp_dat, input bit exp_err,
                      input bit push, output time acc_t);
    exp_t e;
    int   n;
    e.is_rd = !w;
    e.data  = exp_dat;
    e.resp  = exp_err;
    e.waits = exp_err ? 1 : (w ? 0 : 2);
    if (push) begin
      exp_q.push_back(e);
      nm_q.push_back(nm);
    end
    hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = s;
    n = 0;
    forever begin
      @(negedge hclk);
      if (hreadyout) break;
      n++;
      if (n > 50) begin
        checks++;
        $display("FAIL %s: address phase not accepted within 50 cycles", nm);
        break;
      end
    end
    @(posedge hclk);
    acc_t = $time;
    #1;
    hwdata = wd; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    hsel = 1'b0; htrans = 2'b00;
    repeat (n) @(posedge hclk);
    #1;
  endtask

  // Monitor: tracks data phases on the bus and checks each completion against the queue.
  bit mon_dp = 0;
  int mon_stalls = 0;
  bit mon_err1 = 0;
  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        mon_dp = 0;
      end else begin
        if (mon_dp) begin
          if (!hreadyout) begin
            mon_stalls++;
            if (hresp) mon_err1 = 1;
          end else begin
            if (exp_q.size() == 0) begin
              checks++;
              $display("FAIL unexpected_completion: got a data phase, expected none");
            end else begin
              e  = exp_q.pop_front();
              nm = nm_q.pop_front();
              chk({nm, ".waits"}, mon_stalls, e.waits);
              chk({nm, ".hresp"}, {31'd0, hresp}, {31'd0, e.resp});
              if (e.resp) chk({nm, ".err_cycle1"}, {31'd0, mon_err1}, 32'd1);
              if (e.is_rd) chk({nm, ".hrdata"}, hrdata, e.data);
            end
            mon_dp = 0;
          end
        end
        if (!mon_dp && hsel && hready && htrans[1]) begin
          mon_dp = 1;
          mon_stalls = 0;
          mon_err1 = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    time t_w, t_r, t_x;
    #2;
    chk("reset.hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("reset.hresp", {31'd0, hresp}, 32'd0);
    chk("reset.hrdata", hrdata, 32'd0);
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    idle(2);

    // Word write then read with two read wait states
    xfer("t1_wr", 1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 0, 1, t_x);
    xfer("t1_rd", 0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 0, 1, t_x);

    // Byte and halfword lane merging
    xfer("t2_wr_word", 1, 32'h10, 3'd2, 32'h11223344, 32'h0, 0, 1, t_x);
    xfer("t2_wr_byte", 1, 32'h13, 3'd0, 32'hAA000000, 32'h0, 0, 1, t_x);
    xfer("t2_rd_byte", 0, 32'h10, 3'd2, 32'h0, 32'hAA223344, 0, 1, t_x);
    xfer("t2_wr_half", 1, 32'h12, 3'd1, 32'hBEEF0000, 32'h0, 0, 1, t_x);
    xfer("t2_rd_half", 0, 32'h10, 3'd2, 32'h0, 32'hBEEF3344, 0, 1, t_x);

    // Error responses: out of range, misaligned, bad size; memory untouched
    xfer("t3_rd_oor", 0, 32'h400, 3'd2, 32'h0, 32'h0, 1, 1, t_x);
    xfer("t3_wr_misal_word", 1, 32'h12, 3'd2, 32'h55555555, 32'h0, 1, 1, t_x);
    xfer("t3_wr_size3", 1, 32'h10, 3'd3, 32'h66666666, 32'h0, 1, 1, t_x);
    xfer("t3_wr_misal_half", 1, 32'h11, 3'd1, 32'h77777777, 32'h0, 1, 1, t_x);
    xfer("t3_rd_after_err", 0, 32'h10, 3'd2, 32'h0, 32'hBEEF3344, 0, 1, t_x);
    xfer("t3_wr_last", 1, 32'h3FC, 3'd2, 32'hCAFEF00D, 32'h0, 0, 1, t_x);
    xfer("t3_rd_last", 0, 32'h3FC, 3'd2, 32'h0, 32'hCAFEF00D, 0, 1, t_x);

    // Back-to-back write then read with no bubble
    idle(4);
    xfer("t4_wr", 1, 32'h0, 3'd2, 32'h5, 32'h0, 0, 1, t_w);
    xfer("t4_rd", 0, 32'h0, 3'd2, 32'h0, 32'h5, 0, 1, t_r);
    chk("t4_accept_gap", 32'(t_r - t_w), 32'd10);

    // Reset during a read stall
    idle(6);
    xfer("t5_abandoned", 0, 32'h3FC, 3'd2, 32'h0, 32'h0, 0, 0, t_x);
    #2 hresetn = 1'b0;
    #1;
    chk("t5_rst.hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("t5_rst.hresp", {31'd0, hresp}, 32'd0);
    chk("t5_rst.hrdata", hrdata, 32'd0);
    @(posedge hclk);
    #1 hresetn = 1'b1;
    idle(1);
    xfer("t5_rd_after_rst", 0, 32'h10, 3'd2, 32'h0, 32'hBEEF3344, 0, 1, t_x);

    // IDLE transfer and deselected write leave memory unchanged
    xfer("t6_pre_20", 1, 32'h20, 3'd2, 32'h12345678, 32'h0, 0, 1, t_x);
    xfer("t6_pre_24", 1, 32'h24, 3'd2, 32'h9ABCDEF0, 32'h0, 0, 1, t_x);
    idle(4);
    hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
    @(negedge hclk);
    chk("t6_idle.hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("t6_idle.hresp", {31'd0, hresp}, 32'd0);
    @(posedge hclk);
    #1;
    hwdata = 32'hFFFFFFFF;
    hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h24;
    @(negedge hclk);
    chk("t6_nosel.hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("t6_nosel.hresp", {31'd0, hresp}, 32'd0);
    @(posedge hclk);
    #1;
    hwdata = 32'hEEEEEEEE;
    htrans = 2'b00; hwrite = 1'b0;
    @(negedge hclk);
    chk("t6_after.hreadyout", {31'd0, hreadyout}, 32'd1);
    idle(1);
    xfer("t6_rd_20", 0, 32'h20, 3'd2, 32'h0, 32'h12345678, 0, 1, t_x);
    xfer("t6_rd_24", 0, 32'h24, 3'd2, 32'h0, 32'h9ABCDEF0, 0, 1, t_x);

    idle(8);
    chk("drain.pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
